dec32: RTL and testbench

DEC32 -- requirements
Module: dec32

---
 rtl/dec32_pkg.sv | 33 +++
 rtl/dec32_enc.sv | 28 ++
 rtl/dec32.sv | 90 +++++++++
 tb/tb_dec32.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dec32_pkg.sv
// dec32_pkg: widths, RV32 opcode[6:2] index constants and small helpers
// shared by the 5-to-32 decoder and its optional integrity checker.
// Optional feature macro used by the design: DEC32_CHECK_EN.
package dec32_pkg;

  localparam int SEL_W = 5;
  localparam int OUT_W = 32;
  localparam int CNT_W = $clog2(OUT_W) + 1;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] vec_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // RV32 major opcode indices (inst[6:2]) as decoded by this block
  localparam sel_t LOAD   = 5'd0;
  localparam sel_t OP_IMM = 5'd4;
  localparam sel_t AUIPC  = 5'd5;
  localparam sel_t STORE  = 5'd8;
  localparam sel_t OP     = 5'd12;
  localparam sel_t LUI    = 5'd13;
  localparam sel_t BRANCH = 5'd24;
  localparam sel_t JALR   = 5'd25;
  localparam sel_t JAL    = 5'd27;

  // Binary code to one-hot vector; every code maps to exactly one bit.
  function automatic vec_t onehot_of(input sel_t code);
    vec_t v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec32_enc.sv
// dec32_enc: 32-to-5 one-hot to binary encoder with a popcount-is-one flag.
// Only instantiated by dec32 when DEC32_CHECK_EN is defined.
// For a non-one-hot input the code is the OR of all set bit indices, which
// is good enough for a consistency check that also looks at is_one.
module dec32_enc
  import dec32_pkg::*;
(
  input  logic [OUT_W-1:0] vec,
  output logic [SEL_W-1:0] code,
  output logic             is_one
);

  cnt_t cnt;

  // OR-encode set bit positions and count how many bits are set
  always_comb begin
    code = '0;
    cnt  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (vec[i]) begin
        code = code | SEL_W'(i);
        cnt  = cnt + cnt_t'(1);
      end
    end
    is_one = (cnt == cnt_t'(1));
  end

endmodule

// File: rtl/dec32.sv
// dec32: 5-to-32 one-hot decoder with a registered, valid-qualified copy,
// a sticky "seen" mask of decoded codes and an optional one-hot integrity
// checker enabled by the macro DEC32_CHECK_EN (err tied low otherwise).
module dec32
  import dec32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_vld,
  input  logic             clr,
  output logic [OUT_W-1:0] dec,
  output logic [OUT_W-1:0] dec_q,
  output logic             q_vld,
  output logic [OUT_W-1:0] seen,
  output logic             err
);

  // Combinational decode, deliberately not gated by sel_vld or reset
  always_comb begin
    dec = onehot_of(sel);
  end

  // Registered decode: load the one-hot only for valid codes, else zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
      q_vld <= 1'b0;
    end else begin
      dec_q <= sel_vld ? dec : '0;
      q_vld <= sel_vld;
    end
  end

  // Sticky mask; a valid code arriving with clr survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
    end else if (clr) begin
      seen <= sel_vld ? dec : '0;
    end else if (sel_vld) begin
      seen <= seen | dec;
    end
  end

`ifdef DEC32_CHECK_EN
  sel_t sel_q;
  sel_t enc_code;
  logic enc_one;
  logic bad_now;

  // Keep the code that produced dec_q so the re-encoded value can be compared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel;
    end
  end

  dec32_enc u_enc (
    .vec    (dec_q),
    .code   (enc_code),
    .is_one (enc_one)
  );

  // Inconsistency of the registered pair; the code match only means
  // something while q_vld is high since dec_q is zero otherwise
  always_comb begin
    bad_now = 1'b0;
    if (q_vld) begin
      bad_now = !enc_one || (enc_code != sel_q);
    end else begin
      bad_now = (dec_q != '0);
    end
  end

  // err reflects the previous cycle only; it is not sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= bad_now;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dec32.sv
// tb_dec32: directed vectors with hand-computed expectations for dec32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dec32;

  logic        clk;
  logic        rst_n;
  logic [4:0]  sel;
  logic        sel_vld;
  logic        clr;
  logic [31:0] dec;
  logic [31:0] dec_q;
  logic        q_vld;
  logic [31:0] seen;
  logic        err;

  int n_chk = 0;
  int n_bad = 0;

  dec32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .sel_vld (sel_vld),
    .clr     (clr),
    .dec     (dec),
    .dec_q   (dec_q),
    .q_vld   (q_vld),
    .seen    (seen),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] s, input logic v, input logic c);
    sel     = s;
    sel_vld = v;
    clr     = c;
  endtask

  initial begin
    logic [31:0] one;
    one     = 32'h1;
    rst_n   = 1'b0;
    drive(5'd0, 1'b0, 1'b0);
    #1;
    chk("rst_dec_q", dec_q, 32'h0);
    chk("rst_seen",  seen,  32'h0);
    chk("rst_q_vld", {31'h0, q_vld}, 32'h0);
    chk("rst_err",   {31'h0, err},   32'h0);
    sel = 5'd7;
    #1;
    chk("rst_dec_track", dec, 32'h0000_0080);

    @(negedge clk);
    rst_n = 1'b1;

    // sweep with sel_vld low: combinational decode, registered path stays idle
    for (int s = 0; s < 32; s++) begin
      drive(5'(s), 1'b0, 1'b0);
      #1;
      chk("sweep_dec", dec, one << s);
      @(negedge clk);
      chk("sweep_dec_q", dec_q, 32'h0);
      chk("sweep_q_vld", {31'h0, q_vld}, 32'h0);
    end
    chk("sweep_seen", seen, 32'h0);

    // single valid LUI
    drive(5'd13, 1'b1, 1'b0);
    #1;
    chk("lui_dec", dec, 32'h0000_2000);
    @(negedge clk);
    chk("lui_dec_q", dec_q, 32'h0000_2000);
    chk("lui_q_vld", {31'h0, q_vld}, 32'h1);
    chk("lui_seen",  seen,  32'h0000_2000);
    drive(5'd13, 1'b0, 1'b0);
    @(negedge clk);
    chk("lui_dec_q_off", dec_q, 32'h0);
    chk("lui_q_vld_off", {31'h0, q_vld}, 32'h0);

    // plain clear
    drive(5'd3, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_seen", seen, 32'h0);

    // back-to-back valid codes 0, 8, 27
    drive(5'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b0_dec_q", dec_q, 32'h0000_0001);
    chk("b2b0_seen",  seen,  32'h0000_0001);
    drive(5'd8, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b1_dec_q", dec_q, 32'h0000_0100);
    chk("b2b1_seen",  seen,  32'h0000_0101);
    drive(5'd27, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b2_dec_q", dec_q, 32'h0800_0000);
    chk("b2b2_q_vld", {31'h0, q_vld}, 32'h1);
    chk("b2b2_seen",  seen,  32'h0800_0101);
    drive(5'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_seen", seen, 32'h0800_0101);
    drive(5'd5, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr2_seen", seen, 32'h0);

    // clear together with a valid code keeps only the new code
    drive(5'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_seen", seen, 32'h0000_0010);
    drive(5'd24, 1'b1, 1'b1);
    @(negedge clk);
    chk("clrvld_seen",  seen,  32'h0100_0000);
    chk("clrvld_dec_q", dec_q, 32'h0100_0000);
    chk("clrvld_err",   {31'h0, err}, 32'h0);

    // mid-stream reset
    drive(5'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_dec_q", dec_q, 32'h0000_0020);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dec_q", dec_q, 32'h0);
    chk("mid_rst_seen",  seen,  32'h0);
    chk("mid_rst_q_vld", {31'h0, q_vld}, 32'h0);
    chk("mid_rst_err",   {31'h0, err},   32'h0);
    @(negedge clk);
    chk("held_rst_dec_q", dec_q, 32'h0);
    rst_n = 1'b1;
    drive(5'd9, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_rst_dec_q", dec_q, 32'h0000_0200);
    chk("post_rst_q_vld", {31'h0, q_vld}, 32'h1);
    chk("post_rst_seen",  seen,  32'h0000_0200);
    drive(5'd9, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_err", {31'h0, err}, 32'h0);

`ifdef DEC32_CHECK_EN
    drive(5'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_force_err", {31'h0, err}, 32'h0);
    force dut.dec_q = 32'h0000_0011;
    @(negedge clk);
    chk("force_err", {31'h0, err}, 32'h1);
    release dut.dec_q;
    drive(5'd4, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("err_not_sticky", {31'h0, err}, 32'h0);
`else
    drive(5'd4, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("err_tied_low", {31'h0, err}, 32'h0);
    drive(5'd4, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
